picoctrl_prog_ram: RTL

- Parametrised, reloadable, double-banked program store for the PicoCtrl sequencer. It replaces the fixed 32-entry instruction ROM.
- The sequencer fetches from the active bank through a registered read port.
- A byte-wide valid/ready loader fills the shadow bank in the background. A swap request makes the shadow bank active at a clean cycle boundary, so the program can change without stopping the core.

---
 rtl/picoctrl_prog_ram_pkg.sv | 23 ++
 rtl/picoctrl_prog_bank.sv | 41 ++++
 rtl/picoctrl_prog_ram.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/picoctrl_prog_ram_pkg.sv
// ---------------------------------------------------------------------------
// picoctrl_prog_ram_pkg
//   Shared definitions for the PicoCtrl reloadable program store:
//   instruction field widths, the NOP instruction used as filler and idle
//   fetch value, and the encoding of the background loader state machine.
// ---------------------------------------------------------------------------
package picoctrl_prog_ram_pkg;

    // Instruction fields: 4-bit opcode followed by a 12-bit operand.
    localparam int OPC_W = 4;
    localparam int OPR_W = 12;

    localparam logic [OPC_W-1:0] OPC_NOP      = 4'hE;
    localparam logic [15:0]      DEF_NOP_WORD = {OPC_NOP, 12'h000};

    // Loader state machine encoding.
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_FILL = 2'd2
    } ld_state_e;

endpackage

// File: rtl/picoctrl_prog_bank.sv
// ---------------------------------------------------------------------------
// picoctrl_prog_bank
//   One DEPTH x DATA_W program bank: synchronous write port, asynchronous
//   read port. The read result is registered by the parent, which gives the
//   sequencer a single-cycle registered fetch.
//   Ports:
//     clk    - system clock
//     we     - write enable
//     waddr  - write address
//     wdata  - write data
//     raddr  - read address
//     rdata  - read data at raddr
// ---------------------------------------------------------------------------
module picoctrl_prog_bank
    import picoctrl_prog_ram_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/picoctrl_prog_ram.sv
// ---------------------------------------------------------------------------
// picoctrl_prog_ram
//   Double-banked, reloadable program store for the PicoCtrl sequencer.
//   The active bank feeds a registered fetch port; a byte-wide valid/ready
//   loader fills the shadow bank in the background, and a swap request makes
//   the shadow bank active at a clean cycle boundary.
//   Ports:
//     clk, reset             - clock, synchronous active-high reset
//     fetch_addr/fetch_data  - sequencer fetch (1-cycle registered latency)
//     prog_valid             - a bank has been swapped in since reset
//     active_bank            - bank feeding fetch_data
//     ld_start/ld_end        - begin load at word 0 / end program, NOP-fill
//     ld_valid/ld_ready/ld_byte - byte stream, MSB byte of each word first
//     ld_done/ld_error       - pulses: shadow complete / protocol violation
//     ld_count               - words written by the current/last load
//     swap_req/swap_ack      - swap request / pulse when swap performed
// ---------------------------------------------------------------------------
module picoctrl_prog_ram
    import picoctrl_prog_ram_pkg::*;
#(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              prog_valid,
    output logic              active_bank,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    input  logic              ld_end,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_error,
    input  logic              swap_req,
    output logic              swap_ack
);

    localparam int BPW    = DATA_W / 8;
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2 ** ADDR_W - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);

    ld_state_e          state_r, state_s;
    logic [ADDR_W-1:0]  waddr_r, waddr_s;
    logic [BIDX_W-1:0]  byte_idx_r, byte_idx_s;
    logic [DATA_W-1:0]  asm_r, asm_s;
    logic [ADDR_W:0]    count_r, count_s;
    logic               shadow_full_r, shadow_full_s;
    logic               active_bank_r, active_bank_s;
    logic               prog_valid_r, prog_valid_s;
    logic               ld_ready_r, ld_done_r, ld_error_r, swap_ack_r;
    logic               ld_done_s, ld_error_s, swap_ack_s;
    logic [DATA_W-1:0]  fetch_data_r;
    logic               we_s;
    logic [DATA_W-1:0]  wdata_s, next_word_s;
    logic [DATA_W-1:0]  rdata0_s, rdata1_s;

    assign next_word_s = (asm_r << 4'd8) | DATA_W'(ld_byte);

    // Loader FSM, word assembler and swap control: next-state logic.
    always_comb begin
        state_s       = state_r;
        waddr_s       = waddr_r;
        byte_idx_s    = byte_idx_r;
        asm_s         = asm_r;
        count_s       = count_r;
        shadow_full_s = shadow_full_r;
        active_bank_s = active_bank_r;
        prog_valid_s  = prog_valid_r;
        ld_done_s     = 1'b0;
        ld_error_s    = 1'b0;
        swap_ack_s    = 1'b0;
        we_s          = 1'b0;
        wdata_s       = NOP_WORD;

        if (ld_start) begin
            // Start always wins: a concurrent byte is dropped and a load in
            // progress restarts from word 0.
            state_s       = LD_LOAD;
            waddr_s       = '0;
            byte_idx_s    = '0;
            count_s       = '0;
            shadow_full_s = 1'b0;
            ld_error_s    = (state_r != LD_IDLE);
        end else begin
            case (state_r)
                LD_IDLE: begin
                    if (swap_req && shadow_full_r) begin
                        active_bank_s = ~active_bank_r;
                        prog_valid_s  = 1'b1;
                        shadow_full_s = 1'b0;
                        swap_ack_s    = 1'b1;
                    end else begin
                        state_s = LD_IDLE;
                    end
                end
                LD_LOAD: begin
                    if (ld_valid && ld_ready_r) begin
                        asm_s = next_word_s;
                        if (byte_idx_r == LAST_BYTE) begin
                            we_s       = 1'b1;
                            wdata_s    = next_word_s;
                            byte_idx_s = '0;
                            count_s    = count_r + (ADDR_W + 1)'(1);
                            if (waddr_r == LAST_ADDR) begin
                                shadow_full_s = 1'b1;
                                ld_done_s     = 1'b1;
                                state_s       = LD_IDLE;
                            end else begin
                                waddr_s = waddr_r + ADDR_W'(1);
                            end
                        end else begin
                            byte_idx_s = byte_idx_r + BIDX_W'(1);
                        end
                    end else begin
                        asm_s = asm_r;
                    end
                    // A final byte that completes the bank takes precedence
                    // over ld_end (state has already returned to IDLE).
                    if (ld_end && (state_s == LD_LOAD)) begin
                        state_s    = LD_FILL;
                        ld_error_s = (byte_idx_s != '0);
                        byte_idx_s = '0;
                    end else begin
                        ld_error_s = 1'b0;
                    end
                end
                LD_FILL: begin
                    we_s    = 1'b1;
                    wdata_s = NOP_WORD;
                    if (waddr_r == LAST_ADDR) begin
                        shadow_full_s = 1'b1;
                        ld_done_s     = 1'b1;
                        state_s       = LD_IDLE;
                    end else begin
                        waddr_s = waddr_r + ADDR_W'(1);
                    end
                end
                default: begin
                    state_s = LD_IDLE;
                end
            endcase
        end
    end

    // State, status and registered output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= LD_IDLE;
            waddr_r       <= '0;
            byte_idx_r    <= '0;
            asm_r         <= '0;
            count_r       <= '0;
            shadow_full_r <= 1'b0;
            active_bank_r <= 1'b0;
            prog_valid_r  <= 1'b0;
            ld_ready_r    <= 1'b0;
            ld_done_r     <= 1'b0;
            ld_error_r    <= 1'b0;
            swap_ack_r    <= 1'b0;
            fetch_data_r  <= NOP_WORD;
        end else begin
            state_r       <= state_s;
            waddr_r       <= waddr_s;
            byte_idx_r    <= byte_idx_s;
            asm_r         <= asm_s;
            count_r       <= count_s;
            shadow_full_r <= shadow_full_s;
            active_bank_r <= active_bank_s;
            prog_valid_r  <= prog_valid_s;
            ld_ready_r    <= (state_s == LD_LOAD);
            ld_done_r     <= ld_done_s;
            ld_error_r    <= ld_error_s;
            swap_ack_r    <= swap_ack_s;
            // Uses the pre-swap bank select, so the swap cycle still
            // returns an instruction from the old bank.
            fetch_data_r  <= prog_valid_r ? (active_bank_r ? rdata1_s : rdata0_s)
                                          : NOP_WORD;
        end
    end

    // Only the shadow bank (the one not selected by active_bank) is written.
    picoctrl_prog_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk   (clk),
        .we    (we_s && active_bank_r),
        .waddr (waddr_r),
        .wdata (wdata_s),
        .raddr (fetch_addr),
        .rdata (rdata0_s)
    );

    picoctrl_prog_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk   (clk),
        .we    (we_s && !active_bank_r),
        .waddr (waddr_r),
        .wdata (wdata_s),
        .raddr (fetch_addr),
        .rdata (rdata1_s)
    );

    assign fetch_data  = fetch_data_r;
    assign prog_valid  = prog_valid_r;
    assign active_bank = active_bank_r;
    assign ld_ready    = ld_ready_r;
    assign ld_done     = ld_done_r;
    assign ld_count    = count_r;
    assign ld_error    = ld_error_r;
    assign swap_ack    = swap_ack_r;

endmodule
